// File: rtl/snake_move_ctrl.sv
// rtl/snake_move_ctrl.sv - snake head/tail motion, collision check and growth control
module snake_move_ctrl #(
    parameter int WIDTH   = 40,
    parameter int HEIGHT  = 30,
    parameter int MAX_LEN = 64,
    parameter int RD_LAT  = 2
) (
    input  logic       clk_25M,
    input  logic       rst,
    input  logic       step,
    input  logic [1:0] dir_in,
    input  logic [5:0] apple_x,
    input  logic [5:0] apple_y,
    input  logic       check_hit,
    output logic [5:0] head_x,
    output logic [5:0] head_y,
    output logic [5:0] tail_x,
    output logic [5:0] tail_y,
    output logic [5:0] check_x,
    output logic [5:0] check_y,
    output logic [6:0] length,
    output logic       ate,
    output logic       game_over,
    output logic       busy
);
    localparam int DEPTH = MAX_LEN - 1;
    localparam logic signed [6:0] X_LIM = 7'(WIDTH);
    localparam logic signed [6:0] Y_LIM = 7'(HEIGHT);

    typedef enum logic [2:0] {IDLE, CHECK, WAIT, DECIDE, COMMIT, DEAD} state_t;
    state_t state, state_nxt;

    logic [1:0]        cur_dir, dir_eff;
    logic [1:0]        fifo [DEPTH];
    logic [5:0]        rd_ptr, wr_ptr;
    logic [5:0]        next_x, next_y;
    logic [3:0]        wait_cnt;
    logic              eat, eat_r, wall, next_is_tail;
    logic signed [6:0] cand_x, cand_y;

    function automatic logic signed [6:0] dx(input logic [1:0] d);
        case (d)
            2'b01:   return 7'sd1;
            2'b11:   return -7'sd1;
            default: return 7'sd0;
        endcase
    endfunction

    function automatic logic signed [6:0] dy(input logic [1:0] d);
        case (d)
            2'b10:   return 7'sd1;
            2'b00:   return -7'sd1;
            default: return 7'sd0;
        endcase
    endfunction

    function automatic logic [5:0] ptr_inc(input logic [5:0] p);
        return (p == 6'(DEPTH - 1)) ? 6'd0 : p + 6'd1;
    endfunction

    // A request for the exact reverse direction would fold the head onto the neck.
    assign dir_eff      = (dir_in == (cur_dir ^ 2'b10)) ? cur_dir : dir_in;
    assign cand_x       = $signed({1'b0, head_x}) + dx(dir_eff);
    assign cand_y       = $signed({1'b0, head_y}) + dy(dir_eff);
    assign wall         = (cand_x < 7'sd0) || (cand_x >= X_LIM) ||
                          (cand_y < 7'sd0) || (cand_y >= Y_LIM);
    assign eat          = (next_x == apple_x) && (next_y == apple_y) && (length < 7'(MAX_LEN));
    assign next_is_tail = (next_x == tail_x) && (next_y == tail_y);

    assign busy      = (state != IDLE) && (state != DEAD);
    assign game_over = (state == DEAD);
    assign ate       = (state == COMMIT) && eat_r;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (step) state_nxt = wall ? DEAD : CHECK;
            CHECK:   state_nxt = WAIT;
            WAIT:    if (wait_cnt == 4'(RD_LAT - 1)) state_nxt = DECIDE;
            // The tail cell reads as occupied but vacates this move unless we grow.
            DECIDE:  state_nxt = (check_hit && (!next_is_tail || eat)) ? DEAD : COMMIT;
            COMMIT:  state_nxt = IDLE;
            DEAD:    state_nxt = DEAD;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_25M or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            head_x   <= 6'd9;
            head_y   <= 6'd15;
            tail_x   <= 6'd7;
            tail_y   <= 6'd15;
            check_x  <= 6'd9;
            check_y  <= 6'd15;
            next_x   <= 6'd9;
            next_y   <= 6'd15;
            cur_dir  <= 2'b01;
            length   <= 7'd3;
            rd_ptr   <= 6'd0;
            wr_ptr   <= 6'd2;
            wait_cnt <= 4'd0;
            eat_r    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) fifo[i] <= 2'b01;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (step) begin
                    cur_dir <= dir_eff;
                    next_x  <= cand_x[5:0];
                    next_y  <= cand_y[5:0];
                end
                CHECK: begin
                    check_x  <= next_x;
                    check_y  <= next_y;
                    wait_cnt <= 4'd0;
                end
                WAIT:   wait_cnt <= wait_cnt + 4'd1;
                DECIDE: eat_r <= eat;
                COMMIT: begin
                    head_x       <= next_x;
                    head_y       <= next_y;
                    fifo[wr_ptr] <= cur_dir;
                    wr_ptr       <= ptr_inc(wr_ptr);
                    if (eat_r) begin
                        length <= length + 7'd1;
                    end else begin
                        rd_ptr <= ptr_inc(rd_ptr);
                        tail_x <= tail_x + 6'(dx(fifo[rd_ptr]));
                        tail_y <= tail_y + 6'(dy(fifo[rd_ptr]));
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_snake_move_ctrl.sv
// tb/tb_snake_move_ctrl.sv - self-checking bench for snake_move_ctrl against a queue-based body model
module tb_snake_move_ctrl;
    logic       clk_25M = 1'b0;
    logic       rst = 1'b0;
    logic       step = 1'b0;
    logic [1:0] dir_in = 2'b01;
    logic [5:0] apple_x = 6'd63, apple_y = 6'd63;
    logic       check_hit = 1'b0;
    logic [5:0] head_x, head_y, tail_x, tail_y, check_x, check_y;
    logic [6:0] length;
    logic       ate, game_over, busy;

    snake_move_ctrl dut (
        .clk_25M(clk_25M), .rst(rst), .step(step), .dir_in(dir_in),
        .apple_x(apple_x), .apple_y(apple_y), .check_hit(check_hit),
        .head_x(head_x), .head_y(head_y), .tail_x(tail_x), .tail_y(tail_y),
        .check_x(check_x), .check_y(check_y), .length(length),
        .ate(ate), .game_over(game_over), .busy(busy)
    );

    always #20 clk_25M = ~clk_25M;

    typedef struct packed { logic [5:0] x; logic [5:0] y; } cell_t;
    localparam int K_IGN = 0, K_WALL = 1, K_HIT = 2, K_MOVE = 3;

    int errors = 0, checks = 0;
    cell_t body[$];
    logic [1:0] m_dir;
    bit m_dead, m_eat, o_dead, cmp_en = 0, force_hit = 0, s1 = 0;
    cell_t m_check, m_next, o_head, o_tail, o_check;
    int o_len, kind = K_IGN, ph = 8, ate_cnt;
    bit occ [64][64];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Occupancy RAM seen through a two-cycle read pipeline; holds the pre-move body.
    always @(posedge clk_25M) begin
        s1 <= occ[check_x][check_y];
        check_hit <= s1 | force_hit;
    end

    function automatic cell_t ahead(input cell_t c, input logic [1:0] d);
        cell_t r = c;
        case (d)
            2'd0: r.y = c.y - 6'd1;
            2'd1: r.x = c.x + 6'd1;
            2'd2: r.y = c.y + 6'd1;
            default: r.x = c.x - 6'd1;
        endcase
        return r;
    endfunction

    function automatic logic [1:0] eff_dir(input logic [1:0] d);
        return (d == (m_dir ^ 2'b10)) ? m_dir : d;
    endfunction

    task automatic model_reset();
        body.delete();
        body.push_back('{x: 6'd9, y: 6'd15});
        body.push_back('{x: 6'd8, y: 6'd15});
        body.push_back('{x: 6'd7, y: 6'd15});
        m_dir = 2'd1; m_dead = 0; m_check = '{x: 6'd9, y: 6'd15};
        kind = K_IGN; ph = 8;
        o_head = body[0]; o_tail = body[$]; o_len = body.size(); o_check = m_check; o_dead = 0;
    endtask

    task automatic model_step(input logic [1:0] d, input bit fh);
        int nx, ny;
        bit hit;
        if (m_dead) begin kind = K_IGN; return; end
        m_dir = eff_dir(d);
        nx = int'(body[0].x) + ((m_dir == 1) ? 1 : 0) - ((m_dir == 3) ? 1 : 0);
        ny = int'(body[0].y) + ((m_dir == 2) ? 1 : 0) - ((m_dir == 0) ? 1 : 0);
        if (nx < 0 || nx >= 40 || ny < 0 || ny >= 30) begin
            kind = K_WALL; m_dead = 1; return;
        end
        m_next = '{x: 6'(nx), y: 6'(ny)};
        hit = fh;
        foreach (body[i]) if (body[i] == m_next) hit = 1;
        m_eat = (m_next.x == apple_x) && (m_next.y == apple_y) && (body.size() < 64);
        m_check = m_next;
        if (hit && (m_next != body[$] || m_eat)) begin
            kind = K_HIT; m_dead = 1;
        end else begin
            kind = K_MOVE;
            body.push_front(m_next);
            if (!m_eat) void'(body.pop_back());
        end
    endtask

    always @(negedge clk_25M) begin : cmp
        cell_t eh, et, ec;
        int el;
        bit eb, eg, ea;
        if (cmp_en) begin
            eh = o_head; et = o_tail; el = o_len; ec = o_check;
            eb = 0; eg = o_dead; ea = 0;
            case (kind)
                K_WALL: if (ph >= 1) eg = 1;
                K_HIT: begin
                    if (ph >= 2) ec = m_next;
                    if (ph >= 1 && ph <= 4) eb = 1;
                    if (ph >= 5) eg = 1;
                end
                K_MOVE: begin
                    if (ph >= 2) ec = m_next;
                    if (ph >= 1 && ph <= 5) eb = 1;
                    if (ph == 5) ea = m_eat;
                    if (ph >= 6) begin eh = body[0]; et = body[$]; el = body.size(); end
                end
                default: ;
            endcase
            chk("head_x", head_x, eh.x);   chk("head_y", head_y, eh.y);
            chk("tail_x", tail_x, et.x);   chk("tail_y", tail_y, et.y);
            chk("check_x", check_x, ec.x); chk("check_y", check_y, ec.y);
            chk("length", length, el);     chk("busy", busy, eb);
            chk("game_over", game_over, eg); chk("ate", ate, ea);
        end
    end

    task automatic check_reset_values();
        chk("rst_head_x", head_x, 9);  chk("rst_head_y", head_y, 15);
        chk("rst_tail_x", tail_x, 7);  chk("rst_tail_y", tail_y, 15);
        chk("rst_check_x", check_x, 9); chk("rst_check_y", check_y, 15);
        chk("rst_length", length, 3);  chk("rst_busy", busy, 0);
        chk("rst_game_over", game_over, 0); chk("rst_ate", ate, 0);
    endtask

    task automatic do_reset();
        @(negedge clk_25M);
        cmp_en = 0; rst = 0; step = 0;
        #1 check_reset_values();
        @(negedge clk_25M);
        rst = 1;
        model_reset();
        cmp_en = 1;
    endtask

    task automatic do_step(input logic [1:0] d, input bit fh, input bit pulse, input bit rst_mid);
        @(negedge clk_25M);
        o_head = body[0]; o_tail = body[$]; o_len = body.size();
        o_check = m_check; o_dead = m_dead;
        occ = '{default: 0};
        foreach (body[i]) occ[body[i].x][body[i].y] = 1;
        force_hit = fh;
        model_step(d, fh);
        ph = 0; ate_cnt = 0;
        dir_in = d; step = 1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk_25M);
            #1 step = 0; ph = k;
            ate_cnt += int'(ate);
            if (pulse && k == 2) begin dir_in = 2'($urandom); step = 1; end
            if (rst_mid && k == 3) begin
                cmp_en = 0; rst = 0;
                #1 check_reset_values();
                @(negedge clk_25M);
                rst = 1;
                model_reset();
                cmp_en = 1;
                break;
            end
        end
        force_hit = 0;
    endtask

    initial begin
        model_reset();
        // Directed: plain move, eat, reversal, wall, tail chase, forced hit, dropped step, reset mid-move
        do_reset();
        do_step(2'd1, 0, 0, 0);
        chk("t1_head_x", head_x, 10); chk("t1_tail_x", tail_x, 8); chk("t1_length", length, 3);

        do_reset();
        apple_x = 6'd10; apple_y = 6'd15;
        do_step(2'd1, 0, 0, 0);
        chk("t2_head_x", head_x, 10); chk("t2_tail_x", tail_x, 7);
        chk("t2_length", length, 4);  chk("t2_ate_pulses", ate_cnt, 1);
        apple_x = 6'd63; apple_y = 6'd63;

        do_reset();
        do_step(2'd3, 0, 0, 0);
        chk("t3_head_x", head_x, 10);

        do_reset();
        for (int i = 0; i < 30; i++) do_step(2'd1, 0, 0, 0);
        chk("t4_head_x_edge", head_x, 39);
        do_step(2'd1, 0, 0, 0);
        chk("t4_game_over", game_over, 1); chk("t4_head_x", head_x, 39);
        do_step(2'd2, 0, 0, 0);
        chk("t4_frozen_y", head_y, 15);

        do_reset();
        apple_x = 6'd9; apple_y = 6'd14;
        do_step(2'd0, 0, 0, 0);
        apple_x = 6'd63; apple_y = 6'd63;
        do_step(2'd3, 0, 0, 0);
        do_step(2'd2, 0, 0, 0);
        chk("t5_tail_chase_x", head_x, 8); chk("t5_tail_chase_y", head_y, 15);
        chk("t5_alive", game_over, 0);
        do_step(2'd3, 1, 0, 0);
        chk("t5_body_hit", game_over, 1);

        do_reset();
        do_step(2'd1, 0, 1, 0);
        chk("t6_dropped_step", head_x, 10);
        do_step(2'd2, 0, 0, 1);
        do_step(2'd1, 0, 0, 0);
        chk("t6_after_rst_head_x", head_x, 10);

        // Grow along a rectangle until MAX_LEN, then keep moving with the apple ahead
        do_reset();
        for (int i = 0; i < 66; i++) begin
            logic [1:0] d;
            d = m_dir;
            if (d == 2'd1 && body[0].x == 6'd38) d = 2'd2;
            else if (d == 2'd2 && body[0].y == 6'd28) d = 2'd3;
            else if (d == 2'd3 && body[0].x == 6'd1) d = 2'd0;
            else if (d == 2'd0 && body[0].y == 6'd1) d = 2'd1;
            {apple_x, apple_y} = ahead(body[0], d);
            do_step(d, 0, 0, 0);
        end
        chk("max_len_length", length, 64);
        chk("max_len_no_ate", ate_cnt, 0);

        // Randomised play
        for (int r = 0; r < 8; r++) begin
            do_reset();
            for (int s = 0; s < 40; s++) begin
                logic [1:0] d;
                bit was_dead;
                was_dead = m_dead;
                d = 2'($urandom);
                if ($urandom_range(0, 2) == 0) {apple_x, apple_y} = ahead(body[0], eff_dir(d));
                else begin
                    apple_x = 6'($urandom_range(0, 39));
                    apple_y = 6'($urandom_range(0, 29));
                end
                do_step(d, ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0), 0);
                if (was_dead) break;
            end
        end

        cmp_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
